// File: rtl/debounce_pkg.sv
// Shared constants and counter sizing helper for the button debouncer.
// Defaults match a 50 MHz clock with a 4 kHz sample tick.
package debounce_pkg;

   localparam int DEF_CHANNELS       = 5;
   localparam int DEF_SAMPLE_DIV     = 12500;
   localparam int DEF_STABLE_SAMPLES = 4;
   localparam int DEF_REPEAT_DELAY   = 40;
   localparam int DEF_REPEAT_RATE    = 10;

   // Bits needed to hold values 0..max_val (at least 1).
   function automatic int cnt_width(input int max_val);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++)
         if ((max_val >> i) != 0)
            w = i + 1;
      return w;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: 2-flop sync, stability counter, level, edge pulses
// and auto-repeat. Ports: Clock, Reset_n, Tick in; Signal in; Level,
// Pressed, Released, Repeat out (Pressed/Released/Repeat are 1-cycle pulses).
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
   parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE    = DEF_REPEAT_RATE
) (
   input  logic Clock,
   input  logic Reset_n,
   input  logic Tick,
   input  logic Signal,
   output logic Level,
   output logic Pressed,
   output logic Released,
   output logic Repeat
);

   localparam bit REP_EN   = REPEAT_DELAY > 0;
   localparam int STAB_MAX = STABLE_SAMPLES - 1;
   localparam int HOLD_MAX = REP_EN ? REPEAT_DELAY + REPEAT_RATE - 1 : 0;
   localparam int SW       = cnt_width(STAB_MAX);
   localparam int HW       = cnt_width(HOLD_MAX);

   localparam logic [SW-1:0] STAB_LAST = SW'(STAB_MAX);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX);
   localparam logic [HW-1:0] HOLD_FIRE = HW'(REP_EN ? REPEAT_DELAY : 0);

   logic          sync1;
   logic          sync2;
   logic [SW-1:0] stab;
   logic [SW-1:0] stab_nxt;
   logic [HW-1:0] hold;
   logic [HW-1:0] hold_nxt;
   logic [HW-1:0] hold_inc;
   logic          differ;
   logic          accept;
   logic          rise;
   logic          fall;
   logic          rep_nxt;

   always_comb begin
      differ   = sync2 != Level;
      accept   = Tick && differ && (stab == STAB_LAST);
      rise     = accept && !Level;
      fall     = accept && Level;
      hold_inc = hold + 1'b1;
      stab_nxt = stab;
      hold_nxt = hold;
      rep_nxt  = 1'b0;

      if (Tick) begin
         if (!differ || accept)
            stab_nxt = '0;
         else
            stab_nxt = stab + 1'b1;
      end

      // Hold count lives only while the level is high; at the last
      // count it reloads to the first-repeat value so repeats recur.
      if (!Level || fall) begin
         hold_nxt = '0;
      end else if (REP_EN && Tick) begin
         if (hold == HOLD_LAST) begin
            hold_nxt = HOLD_FIRE;
            rep_nxt  = 1'b1;
         end else begin
            hold_nxt = hold_inc;
            rep_nxt  = hold_inc == HOLD_FIRE;
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         stab     <= '0;
         hold     <= '0;
         Level    <= 1'b0;
         Pressed  <= 1'b0;
         Released <= 1'b0;
         Repeat   <= 1'b0;
      end else begin
         sync1    <= Signal;
         sync2    <= sync1;
         stab     <= stab_nxt;
         hold     <= hold_nxt;
         Level    <= Level ^ accept;
         Pressed  <= rise;
         Released <= fall;
         Repeat   <= rep_nxt;
      end
   end

endmodule

// File: rtl/multi_debouncer.sv
// Multi-channel button debouncer: shared sample prescaler plus one
// debounce_channel per input. Ports: Clock, Reset_n, Signal[CHANNELS] in;
// Level, Pressed, Released, Repeat [CHANNELS] out.
module multi_debouncer
   import debounce_pkg::*;
#(
   parameter int CHANNELS       = DEF_CHANNELS,
   parameter int SAMPLE_DIV     = DEF_SAMPLE_DIV,
   parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
   parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE    = DEF_REPEAT_RATE
) (
   input  logic                Clock,
   input  logic                Reset_n,
   input  logic [CHANNELS-1:0] Signal,
   output logic [CHANNELS-1:0] Level,
   output logic [CHANNELS-1:0] Pressed,
   output logic [CHANNELS-1:0] Released,
   output logic [CHANNELS-1:0] Repeat
);

   localparam int PW = cnt_width(SAMPLE_DIV - 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(SAMPLE_DIV - 1);

   logic [PW-1:0] pre_cnt;
   logic          tick;

   assign tick = pre_cnt == PRE_LAST;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n)
         pre_cnt <= '0;
      else if (tick)
         pre_cnt <= '0;
      else
         pre_cnt <= pre_cnt + 1'b1;
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      debounce_channel #(
         .STABLE_SAMPLES (STABLE_SAMPLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_RATE    (REPEAT_RATE)
      ) u_ch (
         .Clock    (Clock),
         .Reset_n  (Reset_n),
         .Tick     (tick),
         .Signal   (Signal[g]),
         .Level    (Level[g]),
         .Pressed  (Pressed[g]),
         .Released (Released[g]),
         .Repeat   (Repeat[g])
      );
   end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer with an event scoreboard.
// Expected pulses (kind, channel, cycle) are queued at drive time.
module tb_multi_debouncer;

   localparam int CH   = 2;
   localparam int DIV  = 4;
   localparam int STB  = 3;
   localparam int DLY  = 5;
   localparam int RATE = 2;
   localparam int ACC  = DIV * STB;

   localparam int K_PRESS = 0;
   localparam int K_REL   = 1;
   localparam int K_REP   = 2;

   logic          Clock = 1'b0;
   logic          Reset_n = 1'b0;
   logic [CH-1:0] Signal = '0;
   logic [CH-1:0] Level;
   logic [CH-1:0] Pressed;
   logic [CH-1:0] Released;
   logic [CH-1:0] Repeat;

   int cyc   = 0;
   int ncmp  = 0;
   int nfail = 0;
   int pr;

   typedef struct packed {
      logic [31:0] at;
      logic [1:0]  kind;
      logic [4:0]  ch;
   } ev_t;

   ev_t  sb[$];
   ev_t  got;
   ev_t  exp_ev;
   logic pulse;

   multi_debouncer #(
      .CHANNELS       (CH),
      .SAMPLE_DIV     (DIV),
      .STABLE_SAMPLES (STB),
      .REPEAT_DELAY   (DLY),
      .REPEAT_RATE    (RATE)
   ) dut (
      .Clock    (Clock),
      .Reset_n  (Reset_n),
      .Signal   (Signal),
      .Level    (Level),
      .Pressed  (Pressed),
      .Released (Released),
      .Repeat   (Repeat)
   );

   always #5 Clock = ~Clock;

   // Edge count since reset release; tick edges are multiples of DIV.
   always @(posedge Clock) begin
      if (!Reset_n)
         cyc = 0;
      else
         cyc = cyc + 1;
   end

   always @(negedge Clock) begin
      for (int c = 0; c < CH; c++) begin
         for (int k = 0; k < 3; k++) begin
            pulse = (k == K_PRESS) ? Pressed[c] :
                    (k == K_REL)   ? Released[c] : Repeat[c];
            if (pulse) begin
               ncmp++;
               assert (sb.size() != 0) else begin
                  nfail++;
                  $error("FAIL unexpected_pulse observed kind=%0d ch=%0d cyc=%0d required none",
                         k, c, cyc);
               end
               if (sb.size() != 0) begin
                  exp_ev    = sb.pop_front();
                  got.at    = 32'(cyc);
                  got.kind  = 2'(k);
                  got.ch    = 5'(c);
                  ncmp++;
                  assert (got === exp_ev) else begin
                     nfail++;
                     $error("FAIL event observed kind=%0d ch=%0d cyc=%0d required kind=%0d ch=%0d cyc=%0d",
                            got.kind, got.ch, got.at, exp_ev.kind, exp_ev.ch, exp_ev.at);
                  end
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed timeout required finish");
      $fatal(1, "timeout");
   end

   task automatic expect_ev(input int at, input int kind, input int ch);
      ev_t e;
      e.at   = 32'(at);
      e.kind = 2'(kind);
      e.ch   = 5'(ch);
      sb.push_back(e);
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] req);
      ncmp++;
      assert (obs === req) else begin
         nfail++;
         $error("FAIL %s observed=%0h required=%0h", tag, obs, req);
      end
   endtask

   // Advance to the falling edge just after the next sample tick edge.
   task automatic to_tick();
      @(negedge Clock);
      while (cyc % DIV != 0)
         @(negedge Clock);
   endtask

   task automatic ticks(input int n);
      repeat (n) to_tick();
   endtask

   initial begin
      Reset_n = 1'b0;
      Signal  = 2'b11;
      repeat (3) @(negedge Clock);
      check("rst_level", 32'(Level), 0);
      check("rst_pressed", 32'(Pressed), 0);
      check("rst_released", 32'(Released), 0);
      check("rst_repeat", 32'(Repeat), 0);

      Reset_n = 1'b1;
      expect_ev(ACC, K_PRESS, 0);
      expect_ev(ACC, K_PRESS, 1);
      ticks(STB);
      check("rst_rel_level", 32'(Level), 32'b11);
      Signal = 2'b00;
      expect_ev(cyc + ACC, K_REL, 0);
      expect_ev(cyc + ACC, K_REL, 1);
      ticks(STB);
      check("both_low", 32'(Level), 0);

      Signal = 2'b01;
      expect_ev(cyc + ACC, K_PRESS, 0);
      ticks(STB);
      check("db_level_hi", 32'(Level), 32'b01);
      Signal = 2'b00;
      expect_ev(cyc + ACC, K_REL, 0);
      ticks(STB);
      check("db_level_lo", 32'(Level), 0);

      Signal = 2'b01;
      ticks(STB - 1);
      Signal = 2'b00;
      ticks(STB);
      check("glitch_level", 32'(Level), 0);

      Signal = 2'b10;
      pr = cyc + ACC;
      expect_ev(pr, K_PRESS, 1);
      for (int n = DLY; n <= 13; n += RATE)
         expect_ev(pr + DIV * n, K_REP, 1);
      for (int i = 0; i < STB + 12; i++) begin
         Signal[0] = ~Signal[0];
         to_tick();
      end
      check("indep_level", 32'(Level), 32'b10);
      Signal = 2'b00;
      expect_ev(cyc + ACC, K_REL, 1);
      ticks(STB + 2);
      check("rep_level_lo", 32'(Level), 0);

      Signal = 2'b10;
      pr = cyc + ACC;
      expect_ev(pr, K_PRESS, 1);
      expect_ev(pr + DIV * DLY, K_REP, 1);
      expect_ev(pr + DIV * (DLY + RATE), K_REP, 1);
      ticks(STB + DLY + RATE);
      #2 Reset_n = 1'b0;
      #1;
      check("mid_rst_level", 32'(Level), 0);
      check("mid_rst_pressed", 32'(Pressed), 0);
      check("mid_rst_released", 32'(Released), 0);
      check("mid_rst_repeat", 32'(Repeat), 0);
      repeat (2) @(negedge Clock);
      Reset_n = 1'b1;
      expect_ev(ACC, K_PRESS, 1);
      ticks(STB);
      check("re_press_level", 32'(Level), 32'b10);
      Signal = 2'b00;
      expect_ev(cyc + ACC, K_REL, 1);
      ticks(STB + 1);
      check("sb_empty", 32'(sb.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
